// File: rtl/tinyml_apb3_master_if.sv
// Bus interfaces for the tinyml APB3 initiator: local command/response channel and APB3 bus.

interface tinyml_cmd_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  rsp_timeout;
  logic                  busy;

  // Local controller issuing commands.
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, busy
  );

  // APB initiator accepting commands.
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, busy
  );
endinterface

interface tinyml_apb3_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERROR;

  // APB requester.
  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERROR
  );

  // APB completer (register bank).
  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERROR
  );
endinterface

// File: rtl/tinyml_apb3_master.sv
// APB3 initiator: turns single-beat local commands into SETUP/ACCESS transfers
// and returns data, slave error and timeout on a valid/ready response channel.

module tinyml_apb3_master #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_CNT_WIDTH   = 9
) (
  input  logic            clk,
  input  logic            reset,
  tinyml_cmd_if.slave     cmd,
  tinyml_apb3_if.master   apb
);

  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TO_LAST_I);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    error_q, error_d;
  logic                    timeout_q, timeout_d;
  logic [TO_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // State and datapath registers; reset aborts any transfer silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          paddr_d  = cmd.cmd_addr;
          pwdata_d = cmd.cmd_wdata;
          pwrite_d = cmd.cmd_write;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (apb.PREADY) begin
          rdata_d   = pwrite_q ? '0 : apb.PRDATA;
          error_d   = apb.PSLVERROR;
          timeout_d = 1'b0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + TO_CNT_WIDTH'(1);
          if (TO_EN && (cnt_q == TO_LAST)) begin
            rdata_d   = '0;
            error_d   = 1'b1;
            timeout_d = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (cmd.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and APB controls decode from the state register only.
  assign apb.PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign apb.PENABLE     = (state_q == S_ACCESS);
  assign apb.PADDR       = paddr_q;
  assign apb.PWRITE      = pwrite_q;
  assign apb.PWDATA      = pwdata_q;
  assign cmd.cmd_ready   = (state_q == S_IDLE);
  assign cmd.rsp_valid   = (state_q == S_RESP);
  assign cmd.busy        = (state_q != S_IDLE);
  assign cmd.rsp_rdata   = rdata_q;
  assign cmd.rsp_error   = error_q;
  assign cmd.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_tinyml_apb3_master.sv
// Self-checking bench for tinyml_apb3_master with a wait-state APB slave model.

module tb_tinyml_apb3_master;

  localparam int TO = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  tinyml_cmd_if  #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) cmd_bus ();
  tinyml_apb3_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) apb_bus ();

  tinyml_apb3_master #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .TO_CNT_WIDTH(9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_bus.slave),
    .apb   (apb_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave behaviour knobs, set per transfer.
  int          s_wait;
  logic        s_never;
  logic        s_err;
  logic [31:0] s_rdata;
  int          s_k;
  logic        s_in_acc;

  // Monitor expectations and observations.
  logic [11:0] exp_addr;
  logic [31:0] exp_wd;
  logic        exp_wr;
  int          psel_cnt;
  int          pen_cnt;
  logic        apb_bad;

  // Slave model: PREADY on the (s_wait+1)-th ACCESS cycle, garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (apb_bus.PSEL && apb_bus.PENABLE) begin
      if (!s_in_acc) s_k = 0; else s_k = s_k + 1;
      s_in_acc = 1'b1;
    end else begin
      s_in_acc = 1'b0;
      s_k = 0;
    end
    apb_bus.PREADY    = apb_bus.PSEL && apb_bus.PENABLE && !s_never && (s_k == s_wait);
    apb_bus.PRDATA    = apb_bus.PREADY ? s_rdata : $urandom;
    apb_bus.PSLVERROR = apb_bus.PREADY ? s_err : 1'($urandom_range(1));
  end

  // Bus monitor: counts select/enable cycles and flags unstable APB payload.
  always @(posedge clk) begin
    #1;
    if (apb_bus.PSEL) psel_cnt = psel_cnt + 1;
    if (apb_bus.PENABLE) pen_cnt = pen_cnt + 1;
    if (apb_bus.PENABLE && !apb_bus.PSEL) apb_bad = 1'b1;
    if (apb_bus.PSEL && ((apb_bus.PADDR !== exp_addr) || (apb_bus.PWRITE !== exp_wr) ||
                         (apb_bus.PWDATA !== exp_wd)))
      apb_bad = 1'b1;
  end

  // One transfer, called at a negedge with the DUT in IDLE.
  task automatic do_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                         input int wt, input logic nev, input logic er, input logic [31:0] rd,
                         input int hold, input logic nxt_valid, input logic [11:0] nxt_addr);
    int          acc;
    logic        to;
    logic [31:0] erd;
    logic        eer;
    int          n;
    int          pc;
    to  = nev || (wt >= TO);
    acc = to ? TO : wt + 1;
    erd = (to || wr) ? 32'h0 : rd;
    eer = to || er;
    s_wait = wt; s_never = nev; s_err = er; s_rdata = rd;
    exp_addr = addr; exp_wd = wd; exp_wr = wr;
    psel_cnt = 0; pen_cnt = 0; apb_bad = 1'b0;

    vectors++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_bus.cmd_ready);
    end
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_write = wr;
    cmd_bus.cmd_addr = addr; cmd_bus.cmd_wdata = wd;
    cmd_bus.rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_addr  = 12'($urandom);
    cmd_bus.cmd_wdata = $urandom;
    cmd_bus.cmd_write = ~wr;
    n = 1;
    while (!cmd_bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end

    vectors++;
    if (n !== 2 + acc) begin
      miscompares++; $display("FAIL rsp_latency addr=%h got=%0d exp=%0d", addr, n, 2 + acc);
    end
    vectors++;
    if ({cmd_bus.rsp_rdata, cmd_bus.rsp_error, cmd_bus.rsp_timeout} !== {erd, eer, to}) begin
      miscompares++;
      $display("FAIL rsp_fields addr=%h got=%h/%b/%b exp=%h/%b/%b", addr, cmd_bus.rsp_rdata,
               cmd_bus.rsp_error, cmd_bus.rsp_timeout, erd, eer, to);
    end
    vectors++;
    if ((psel_cnt !== 1 + acc) || (pen_cnt !== acc) || (apb_bad !== 1'b0)) begin
      miscompares++;
      $display("FAIL apb_phases addr=%h got psel=%0d pen=%0d bad=%b exp psel=%0d pen=%0d bad=0",
               addr, psel_cnt, pen_cnt, apb_bad, 1 + acc, acc);
    end
    vectors++;
    if ({cmd_bus.busy, cmd_bus.cmd_ready} !== 2'b10) begin
      miscompares++; $display("FAIL resp_busy got=%b%b exp=10", cmd_bus.busy, cmd_bus.cmd_ready);
    end

    pc = psel_cnt;
    for (int i = 0; i < hold; i++) begin
      if (nxt_valid) begin
        cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_addr = nxt_addr; cmd_bus.cmd_wdata = $urandom;
      end
      @(negedge clk);
      vectors++;
      if ((cmd_bus.rsp_valid !== 1'b1) || (cmd_bus.cmd_ready !== 1'b0) ||
          ({cmd_bus.rsp_rdata, cmd_bus.rsp_error, cmd_bus.rsp_timeout} !== {erd, eer, to}) ||
          (psel_cnt !== pc) || (apb_bus.PADDR !== addr)) begin
        miscompares++;
        $display("FAIL rsp_hold cyc=%0d got v=%b rdy=%b d=%h psel=%0d paddr=%h exp v=1 rdy=0 d=%h psel=%0d paddr=%h",
                 i, cmd_bus.rsp_valid, cmd_bus.cmd_ready, cmd_bus.rsp_rdata, psel_cnt,
                 apb_bus.PADDR, erd, pc, addr);
      end
    end
    cmd_bus.rsp_ready = 1'b1;
    @(negedge clk);
    cmd_bus.rsp_ready = 1'b0;
    vectors++;
    if ({cmd_bus.rsp_valid, cmd_bus.cmd_ready, cmd_bus.busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL after_handshake got v/rdy/busy=%b%b%b exp=010", cmd_bus.rsp_valid,
               cmd_bus.cmd_ready, cmd_bus.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, cmd_bus.rsp_valid, cmd_bus.rsp_error,
         cmd_bus.rsp_timeout, cmd_bus.busy, cmd_bus.cmd_ready} !== 8'b0000_0001) begin
      miscompares++; $display("FAIL reset_ctrl got=%b%b%b%b%b%b%b%b exp=00000001",
        apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, cmd_bus.rsp_valid, cmd_bus.rsp_error,
        cmd_bus.rsp_timeout, cmd_bus.busy, cmd_bus.cmd_ready);
    end
    vectors++;
    if ({apb_bus.PADDR, apb_bus.PWDATA, cmd_bus.rsp_rdata} !== 76'h0) begin
      miscompares++; $display("FAIL reset_data got=%h/%h/%h exp=0", apb_bus.PADDR,
                              apb_bus.PWDATA, cmd_bus.rsp_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_xfer(1'b1, 12'h000, 32'h0000_00FF, 0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 12'h0);
    do_xfer(1'b0, 12'h040, 32'h5555_AAAA, 1, 1'b0, 1'b0, 32'hABCD_5678, 0, 1'b0, 12'h0);
    do_xfer(1'b0, 12'h080, 32'h0, 0, 1'b0, 1'b1, 32'h1234_5678, 0, 1'b0, 12'h0);
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 12'h100, 32'h0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 12'h0);
    do_xfer(1'b0, 12'h104, 32'h0, TO - 1, 1'b0, 1'b0, 32'hCAFE_F00D, 0, 1'b0, 12'h0);
    do_xfer(1'b1, 12'h108, 32'h0BAD_0BAD, 0, 1'b1, 1'b1, 32'h1111_2222, 0, 1'b0, 12'h0);
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 12'h200, 32'h0F0F_0F0F, 0, 1'b0, 1'b0, 32'h0, 5, 1'b1, 12'h300);
    do_xfer(1'b0, 12'h300, 32'h7777_7777, 0, 1'b0, 1'b0, 32'h8765_4321, 0, 1'b0, 12'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      do_xfer(1'($urandom_range(1)), 12'($urandom), $urandom, int'($urandom_range(0, 5)),
              ($urandom_range(0, 7) == 0), 1'($urandom_range(1)), $urandom,
              int'($urandom_range(0, 2)), 1'b0, 12'h0);
  endtask

  task automatic test_reset_mid_access();
    s_never = 1'b1; exp_addr = 12'h3C0; exp_wd = 32'h1; exp_wr = 1'b0;
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_write = 1'b0;
    cmd_bus.cmd_addr = 12'h3C0; cmd_bus.cmd_wdata = 32'h1; cmd_bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (apb_bus.PENABLE !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_access got=%b exp=1", apb_bus.PENABLE);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({apb_bus.PSEL, apb_bus.PENABLE, cmd_bus.busy, cmd_bus.rsp_valid} !== 4'b0000) begin
      miscompares++; $display("FAIL async_reset got=%b%b%b%b exp=0000", apb_bus.PSEL,
                              apb_bus.PENABLE, cmd_bus.busy, cmd_bus.rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({cmd_bus.cmd_ready, cmd_bus.rsp_valid, apb_bus.PSEL} !== 3'b100) begin
        miscompares++; $display("FAIL post_reset got rdy/v/psel=%b%b%b exp=100",
                                cmd_bus.cmd_ready, cmd_bus.rsp_valid, apb_bus.PSEL);
      end
    end
    do_xfer(1'b0, 12'h044, 32'h0, 2, 1'b0, 1'b0, 32'h5A5A_A5A5, 0, 1'b0, 12'h0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1;
    cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_write = 1'b0; cmd_bus.cmd_addr = '0;
    cmd_bus.cmd_wdata = '0; cmd_bus.rsp_ready = 1'b0;
    apb_bus.PREADY = 1'b0; apb_bus.PRDATA = '0; apb_bus.PSLVERROR = 1'b0;
    s_wait = 0; s_never = 1'b0; s_err = 1'b0; s_rdata = '0; s_k = 0; s_in_acc = 1'b0;
    exp_addr = '0; exp_wd = '0; exp_wr = 1'b0; psel_cnt = 0; pen_cnt = 0; apb_bad = 1'b0;
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tinyml_apb3_master.md
Name: tinyml_apb3_master

Overview:
- APB3 initiator (requester side of the APB3 bus). Converts single-beat commands from a local controller (DMA sequencer, test FSM, bridge) into APB3 SETUP/ACCESS transfers.
- Drives the tinyml register-bank slaves (camera/DMA/accelerator control and debug registers).
- Returns read data, slave error and a timeout indication on a valid/ready response channel.
- One transfer in flight at a time.

Parameters:
- ADDR_WIDTH, 12, PADDR/cmd_addr width.
- DATA_WIDTH, 32, PWDATA/PRDATA/cmd/rsp data width.
- TIMEOUT_CYCLES, 256, max ACCESS cycles waiting for PREADY; 0 disables timeout.
- TO_CNT_WIDTH, 9, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_error  out  1  PSLVERROR sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  state != IDLE.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  slave read data.
- PSLVERROR  in  1  slave error.

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - State = IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_error, rsp_timeout, busy = 0.
  - PADDR, PWDATA, rsp_rdata = 0.
  - Timeout counter = 0.
  - An aborted transfer produces no response.
- State machine: IDLE, SETUP, ACCESS, RESP. All outputs registered or decoded from state only; no combinational path from inputs to APB outputs.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch cmd_addr→PADDR, cmd_wdata→PWDATA, cmd_write→PWRITE; go to SETUP.
  - PWDATA is latched for reads too.
- SETUP: exactly one cycle with PSEL=1, PENABLE=0; then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA held stable.
  - Timeout counter increments each cycle PREADY=0.
  - On PREADY=1:
    - rsp_rdata = PWRITE ? 0 : PRDATA.
    - rsp_error = PSLVERROR; rsp_timeout = 0.
    - Go to RESP.
  - Timeout: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with PREADY=0, the next edge goes to RESP with rsp_error=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 in the same cycle as the timeout boundary: PREADY wins, normal completion.
- RESP:
  - PSEL=0, PENABLE=0; rsp_valid=1 and held with stable data until rsp_ready.
  - The rsp_valid & rsp_ready edge returns to IDLE.
  - cmd_ready = 0.
- Latency, minimum (zero-wait-state slave, rsp_ready tied high):
  - Accept edge T.
  - SETUP during T+1, ACCESS during T+2.
  - rsp_valid during T+3.
  - Next command accepted at T+4.
- Each wait state adds one cycle.
- PSEL never deasserts between SETUP and ACCESS. No back-to-back transfer without passing through IDLE.
- Timeout counter clears on entry to SETUP.
- cmd_* inputs are ignored outside IDLE.
- rsp_ready is ignored outside RESP.

Test Plan:
- Write 0x0000_00FF to 0x000, slave PREADY=1 in first ACCESS cycle:
  - PSEL high 2 cycles, PENABLE high 1 cycle, PWRITE=1, PWDATA=0x0000_00FF.
  - rsp_valid 3 cycles after accept, rsp_rdata=0, rsp_error=0.
- Read 0x040, slave model returns 0xABCD_5678 after 1 wait state:
  - ACCESS lasts 2 cycles.
  - rsp_rdata=0xABCD_5678, rsp_error=0, rsp_timeout=0.
- Read with PSLVERROR=1 at PREADY, PRDATA=0x1234_5678 → rsp_error=1, rsp_timeout=0, rsp_rdata=0x1234_5678.
- TIMEOUT_CYCLES=4, slave never asserts PREADY:
  - ACCESS exactly 4 cycles, then PSEL=0.
  - rsp_error=1, rsp_timeout=1, rsp_rdata=0.
- rsp_ready held low 5 cycles while a new cmd_valid is presented:
  - rsp_valid and data stay stable; cmd_ready=0; no APB activity.
  - After the handshake, the new command is accepted in IDLE.
- reset asserted during ACCESS:
  - PSEL/PENABLE drop before the next clock edge; no rsp_valid.
  - After release, state IDLE with cmd_ready=1.
